// File: rtl/std_delay_line.sv
// Runtime-configurable, stallable delay line: per-sample valid tagging, flush,
// delay reprogramming (with implicit flush) and occupancy reporting.
module std_delay_line #(
    parameter int  MAX_DELAY     = 4,
    parameter int  WIDTH         = 8,
    parameter type TYPE          = logic [WIDTH-1:0],
    parameter int  DEFAULT_DELAY = 1,
    parameter int  DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_flush,
    input  logic          i_delay_wr,
    input  logic [DW-1:0] i_delay,
    input  logic          i_valid,
    input  TYPE           i_d,
    output logic          o_valid,
    output TYPE           o_d,
    output logic [DW-1:0] o_delay,
    output logic [DW-1:0] o_occupancy
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    TYPE                  stage_data_q [MAX_DELAY];
    TYPE                  stage_data_d [MAX_DELAY];
    logic [MAX_DELAY-1:0] stage_vld_q;
    logic [MAX_DELAY-1:0] stage_vld_d;
    logic [DW-1:0]        cur_delay_q;
    logic [DW-1:0]        cur_delay_d;
    logic [DW-1:0]        occ_q;
    logic [DW-1:0]        occ_d;

    logic                 clear_s;
    logic                 live_s;
    logic                 accept_s;
    logic                 emit_s;
    logic                 tap_vld_s;
    TYPE                  tap_data_s;
    logic [DW-1:0]        delay_clamped_s;

    // Control qualifiers; reset also suppresses emission in its own cycle.
    always_comb begin
        clear_s  = i_flush | i_delay_wr;
        live_s   = i_en & ~clear_s & ~i_rst;
        accept_s = i_valid & live_s;
        if (i_delay > MAX_D) begin
            delay_clamped_s = MAX_D;
        end else begin
            delay_clamped_s = i_delay;
        end
    end

    // Tap select: stage[cur_delay-1]; no match (delay 0) leaves the tap invalid.
    always_comb begin
        tap_data_s = stage_data_q[0];
        tap_vld_s  = 1'b0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (cur_delay_q == DW'(k + 1)) begin
                tap_data_s = stage_data_q[k];
                tap_vld_s  = stage_vld_q[k];
            end else begin
                tap_data_s = tap_data_s;
                tap_vld_s  = tap_vld_s;
            end
        end
    end

    // Output port: delay 0 is a pure combinational bypass.
    always_comb begin
        if (cur_delay_q == {DW{1'b0}}) begin
            o_d     = i_d;
            o_valid = accept_s;
            emit_s  = 1'b0;
        end else begin
            o_d     = tap_data_s;
            o_valid = tap_vld_s & live_s;
            emit_s  = tap_vld_s & live_s;
        end
        o_delay     = cur_delay_q;
        o_occupancy = occ_q;
    end

    // Next-state: clear beats advance; stages past the active tap never hold a valid sample.
    always_comb begin
        stage_data_d = stage_data_q;
        stage_vld_d  = stage_vld_q;
        cur_delay_d  = cur_delay_q;
        occ_d        = occ_q;
        if (clear_s) begin
            stage_vld_d = {MAX_DELAY{1'b0}};
            occ_d       = {DW{1'b0}};
            if (i_delay_wr) begin
                cur_delay_d = delay_clamped_s;
            end else begin
                cur_delay_d = cur_delay_q;
            end
        end else if (i_en) begin
            stage_data_d[0] = i_d;
            stage_vld_d[0]  = i_valid;
            for (int k = 1; k < MAX_DELAY; k++) begin
                stage_data_d[k] = stage_data_q[k-1];
                stage_vld_d[k]  = stage_vld_q[k-1];
            end
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (DW'(k) >= cur_delay_q) begin
                    stage_vld_d[k] = 1'b0;
                end else begin
                    stage_vld_d[k] = stage_vld_d[k];
                end
            end
            if (cur_delay_q == {DW{1'b0}}) begin
                occ_d = {DW{1'b0}};
            end else begin
                case ({accept_s, emit_s})
                    2'b10:   occ_d = occ_q + {{(DW-1){1'b0}}, 1'b1};
                    2'b01:   occ_d = occ_q - {{(DW-1){1'b0}}, 1'b1};
                    default: occ_d = occ_q;
                endcase
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                stage_data_q[k] <= '0;
            end
            stage_vld_q <= {MAX_DELAY{1'b0}};
            cur_delay_q <= DEF_D;
            occ_q       <= {DW{1'b0}};
        end else begin
            stage_data_q <= stage_data_d;
            stage_vld_q  <= stage_vld_d;
            cur_delay_q  <= cur_delay_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_std_delay_line.sv
// Directed self-checking bench for std_delay_line (MAX_DELAY=4, WIDTH=8, DEFAULT_DELAY=1).
module tb_std_delay_line;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic       dwr;
    logic [2:0] dly;
    logic       vld;
    logic [7:0] din;
    logic       ov;
    logic [7:0] od;
    logic [2:0] odly;
    logic [2:0] occ;

    int n_checks = 0;
    int n_errors = 0;
    int occ_t2 [12] = '{0, 1, 2, 2, 3, 3, 3, 4, 4, 3, 2, 1};

    always #5 clk = ~clk;

    std_delay_line dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_flush     (flush),
        .i_delay_wr  (dwr),
        .i_delay     (dly),
        .i_valid     (vld),
        .i_d         (din),
        .o_valid     (ov),
        .o_d         (od),
        .o_delay     (odly),
        .o_occupancy (occ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, check the same-cycle output, then advance.
    task automatic cyc(input string tag, input logic e, input logic f, input logic w,
                       input logic [2:0] dl, input logic v, input logic [7:0] d,
                       input logic ev, input logic [7:0] ed);
        en = e; flush = f; dwr = w; dly = dl; vld = v; din = d;
        #1;
        check({tag, ".valid"}, 32'(ov), 32'(ev));
        if (ev) check({tag, ".data"}, 32'(od), 32'(ed));
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; dwr = 1'b0; dly = 3'd0; vld = 1'b0; din = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        #1;
        check("rst.valid", 32'(ov), 32'd0);
        check("rst.data", 32'(od), 32'h00);
        check("rst.delay", 32'(odly), 32'd1);
        check("rst.occ", 32'(occ), 32'd0);

        // Default delay 1
        cyc("t1c1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h11, 1'b0, 8'h00);
        check("t1c2.occ", 32'(occ), 32'd1);
        cyc("t1c2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h22, 1'b1, 8'h11);
        check("t1c3.occ", 32'(occ), 32'd1);
        cyc("t1c3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h33, 1'b1, 8'h22);
        cyc("t1c4", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h33);
        check("t1c5.occ", 32'(occ), 32'd0);
        cyc("t1c5", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Maximum delay with a bubble in slot 2
        cyc("t2wr", 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t2.delay", 32'(odly), 32'd4);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t2.occ%0d", i), 32'(occ), 32'(occ_t2[i]));
            cyc($sformatf("t2.s%0d", i), 1'b1, 1'b0, 1'b0, 3'd0,
                (i < 8) && (i != 2), 8'(8'hA0 + i),
                (i >= 4) && (i != 6), 8'(8'hA0 + i - 4));
        end

        // Stall with delay 3: accepted in "cycle 10", emitted in "cycle 15"
        cyc("t3wr", 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc("t3c10", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h55, 1'b0, 8'h00);
        check("t3c11.occ", 32'(occ), 32'd1);
        cyc("t3c11", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h66, 1'b0, 8'h00);
        check("t3c12.occ", 32'(occ), 32'd1);
        cyc("t3c12", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h67, 1'b0, 8'h00);
        cyc("t3c13", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc("t3c14", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc("t3c15", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h55);
        cyc("t3c16", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Flush with delay 4 drops everything in flight plus the flush-cycle input
        cyc("t4wr", 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc("t4b1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hB1, 1'b0, 8'h00);
        cyc("t4b2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hB2, 1'b0, 8'h00);
        cyc("t4b3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hB3, 1'b0, 8'h00);
        check("t4.occ_pre", 32'(occ), 32'd3);
        cyc("t4fl", 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'hB4, 1'b0, 8'h00);
        check("t4.occ_post", 32'(occ), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("t4.idle%0d", i), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);
        end

        // Delay 0 bypass and clamping
        cyc("t5wr0", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t5.delay0", 32'(odly), 32'd0);
        cyc("t5d0", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h7E, 1'b1, 8'h7E);
        check("t5.occ0", 32'(occ), 32'd0);
        cyc("t5stall", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h3C, 1'b0, 8'h00);
        cyc("t5wr7", 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t5.clamp", 32'(odly), 32'd4);

        // Reset mid-stream with delay 2
        cyc("t6wr", 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00);
        cyc("t6c0", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hC0, 1'b0, 8'h00);
        cyc("t6c1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hC1, 1'b0, 8'h00);
        cyc("t6c2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hC2, 1'b1, 8'hC0);
        cyc("t6c3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hC3, 1'b1, 8'hC1);
        check("t6.occ_full", 32'(occ), 32'd2);
        rst = 1'b1;
        cyc("t6rst", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hC4, 1'b0, 8'h00);
        rst = 1'b0;
        check("t6.delay", 32'(odly), 32'd1);
        check("t6.occ", 32'(occ), 32'd0);
        cyc("t6d0", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hD0, 1'b0, 8'h00);
        cyc("t6d1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 8'hD0);
        cyc("t6d2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
